// File: rtl/acc_pkg.sv
// Shared types and helpers for the accelerator offload issue path.
// - op_sel_e / imm_sel_e: operand source and RISC-V immediate format selectors.
// - offl_instr_t: one match/decode table entry.
// - acc_issue_req_t: issue FIFO payload for the default 3 x 32-bit configuration.
// - imm_decode / offl_match: immediate extraction and table-entry match helpers.
package acc_pkg;

    localparam int unsigned AccDataWidth = 32;
    localparam int unsigned AccNumRs     = 3;

    typedef enum logic [1:0] {
        OP_RS  = 2'd0,
        OP_IMM = 2'd1
    } op_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef struct packed {
        logic [31:0] instr_data;
        logic [31:0] instr_mask;
        op_sel_e     op_a_mux;
        op_sel_e     op_b_mux;
        op_sel_e     op_c_mux;
        imm_sel_e    imm_a_mux;
        imm_sel_e    imm_b_mux;
        imm_sel_e    imm_c_mux;
        logic [2:0]  use_rs;
        logic [1:0]  writeback;
    } offl_instr_t;

    typedef struct packed {
        logic [31:0]                       instr;
        logic [AccNumRs*AccDataWidth-1:0]  ops;
        logic [1:0]                        wb;
    } acc_issue_req_t;

    // Returns the immediate sign-extended to 32 bits; callers widen further with a signed cast.
    function automatic logic [31:0] imm_decode(input logic [31:0] instr, input imm_sel_e sel);
        logic [31:0] imm;
        unique case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic offl_match(input logic [31:0] instr, input offl_instr_t entry);
        return (instr & entry.instr_mask) == entry.instr_data;
    endfunction

endpackage

// File: rtl/acc_issue_fifo.sv
// Depth-entry issue FIFO with flush and simultaneous pop-and-push when full.
// Ports: clk_i/rst_i (async active-high), flush_i drops all entries, push_i/wb_i/data_i write,
// pop_i reads, valid_o = not empty, full_o, data_o = head entry, flush_wb_cnt_o = number of
// writeback entries discarded if flush_i is taken this cycle.
module acc_issue_fifo import acc_pkg::*; #(
    parameter int unsigned Depth = 2,
    parameter type         req_t = acc_issue_req_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       wb_i,
    input  req_t                       data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic                       full_o,
    output req_t                       data_o,
    output logic [$clog2(Depth+1)-1:0] flush_wb_cnt_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    req_t            mem_q [Depth];
    logic [Depth-1:0] wb_q, wb_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wb_d     = wb_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            wb_d     = '0;
        end else begin
            // Clear before set so a pop-and-push on the same slot keeps the new flag.
            if (pop_i) begin
                rd_ptr_d       = ptr_inc(rd_ptr_q);
                wb_d[rd_ptr_q] = 1'b0;
            end
            if (push_i) begin
                wr_ptr_d       = ptr_inc(wr_ptr_q);
                wb_d[wr_ptr_q] = wb_i;
            end
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // A head entry popped in the flush cycle was really issued, so its credit is not returned.
    always_comb begin
        flush_wb_cnt_o = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (wb_q[i] && !(pop_i && (PtrW'(i) == rd_ptr_q))) begin
                flush_wb_cnt_o = flush_wb_cnt_o + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wb_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wb_q     <= wb_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/acc_offload_issue.sv
// Offload issue stage: matches core instructions against OfflInstrTable, resolves NumRs
// operands from registers or immediates, queues accepted offloads and tracks writeback credits.
// Ports: clk_i/rst_i (async active-high); instr_* core handshake with instr_accept_o marking an
// offload; rs_i/rs_valid_i register operands; flush_i drops queued requests; acc_req_* request
// output; acc_rsp_valid_i/acc_rsp_ready_o writeback responses; outstanding_o credit count.
module acc_offload_issue import acc_pkg::*; #(
    parameter int unsigned                NumInstr       = 4,
    parameter int unsigned                NumRs          = 3,
    parameter int unsigned                DataWidth      = 32,
    parameter int unsigned                Depth          = 2,
    parameter int unsigned                MaxOutstanding = 4,
    parameter offl_instr_t [NumInstr-1:0] OfflInstrTable = '0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  instr_valid_i,
    output logic                                  instr_ready_o,
    input  logic [31:0]                           instr_data_i,
    input  logic [NumRs*DataWidth-1:0]            rs_i,
    input  logic [NumRs-1:0]                      rs_valid_i,
    output logic                                  instr_accept_o,
    input  logic                                  flush_i,
    output logic                                  acc_req_valid_o,
    input  logic                                  acc_req_ready_i,
    output logic [31:0]                           acc_req_instr_o,
    output logic [NumRs*DataWidth-1:0]            acc_req_op_o,
    output logic [1:0]                            acc_req_wb_o,
    input  logic                                  acc_rsp_valid_i,
    output logic                                  acc_rsp_ready_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam int unsigned FlW  = $clog2(Depth + 1);

    typedef struct packed {
        logic [31:0]                 instr;
        logic [NumRs*DataWidth-1:0]  ops;
        logic [1:0]                  wb;
    } issue_req_t;

    logic                       match;
    offl_instr_t                hit;
    op_sel_e                    op_sel  [3];
    imm_sel_e                   imm_sel [3];
    logic [NumRs*DataWidth-1:0] ops;
    logic [NumRs-1:0]           rs_needed;
    logic                       rs_ok, credit_ok, fifo_ok, push, pop;
    logic                       fifo_valid, fifo_full;
    logic [FlW-1:0]             flush_wb_cnt;
    issue_req_t                 push_req, head_req;
    logic [OutW-1:0]            outstanding_q, outstanding_d;
    int                         out_sum;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        match = 1'b0;
        hit   = '0;
        for (int i = int'(NumInstr) - 1; i >= 0; i--) begin
            if (offl_match(instr_data_i, OfflInstrTable[i])) begin
                match = 1'b1;
                hit   = OfflInstrTable[i];
            end
        end
    end

    assign op_sel  = '{hit.op_a_mux, hit.op_b_mux, hit.op_c_mux};
    assign imm_sel = '{hit.imm_a_mux, hit.imm_b_mux, hit.imm_c_mux};

    always_comb begin
        ops       = '0;
        rs_needed = '0;
        for (int k = 0; k < int'(NumRs); k++) begin
            case (op_sel[k])
                OP_RS:   ops[k*DataWidth +: DataWidth] = rs_i[k*DataWidth +: DataWidth];
                OP_IMM:  ops[k*DataWidth +: DataWidth] =
                             DataWidth'($signed(imm_decode(instr_data_i, imm_sel[k])));
                default: ops[k*DataWidth +: DataWidth] = '0;
            endcase
            rs_needed[k] = hit.use_rs[k] && (op_sel[k] == OP_RS);
        end
    end

    assign rs_ok     = &(rs_valid_i | ~rs_needed);
    assign fifo_ok   = !fifo_full || acc_req_ready_i;
    assign credit_ok = (hit.writeback == 2'b00) || (outstanding_q < OutW'(MaxOutstanding)) ||
                       acc_rsp_valid_i;

    // Non-offload instructions are rejected at once; offloads wait for operands and space.
    assign instr_ready_o  = !rst_i && (!match || (!flush_i && rs_ok && fifo_ok && credit_ok));
    assign instr_accept_o = match;

    assign push = instr_valid_i && instr_ready_o && match;
    assign pop  = fifo_valid && acc_req_ready_i;

    assign push_req = '{instr: instr_data_i, ops: ops, wb: hit.writeback};

    acc_issue_fifo #(
        .Depth (Depth),
        .req_t (issue_req_t)
    ) u_fifo (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .push_i         (push),
        .wb_i           (hit.writeback != 2'b00),
        .data_i         (push_req),
        .pop_i          (pop),
        .valid_o        (fifo_valid),
        .full_o         (fifo_full),
        .data_o         (head_req),
        .flush_wb_cnt_o (flush_wb_cnt)
    );

    assign acc_req_valid_o = fifo_valid;
    assign acc_req_instr_o = head_req.instr;
    assign acc_req_op_o    = head_req.ops;
    assign acc_req_wb_o    = head_req.wb;
    assign acc_rsp_ready_o = 1'b1;
    assign outstanding_o   = outstanding_q;

    always_comb begin
        out_sum = int'(outstanding_q) + int'(push && (hit.writeback != 2'b00)) -
                  int'(acc_rsp_valid_i) - (flush_i ? int'(flush_wb_cnt) : 0);
        if (out_sum < 0) begin
            out_sum = 0;
        end
        outstanding_d = OutW'(out_sum);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(acc_rsp_valid_i && (outstanding_q == '0) &&
                      !(push && (hit.writeback != 2'b00))))
                else $error("writeback response with no offload outstanding");
        end
    end

endmodule

// File: tb/tb_acc_offload_issue.sv
// Directed self-checking bench for acc_offload_issue (Depth=2, MaxOutstanding=2).
module tb_acc_offload_issue;
    import acc_pkg::*;

    localparam offl_instr_t E0 = '{instr_data: 32'h0000002B, instr_mask: 32'hFE00707F,
        op_a_mux: OP_RS, op_b_mux: OP_RS, op_c_mux: OP_RS,
        imm_a_mux: IMM_I, imm_b_mux: IMM_I, imm_c_mux: IMM_I, use_rs: 3'b011, writeback: 2'd1};
    localparam offl_instr_t E1 = '{instr_data: 32'h0000005B, instr_mask: 32'h0000707F,
        op_a_mux: OP_RS, op_b_mux: OP_IMM, op_c_mux: OP_IMM,
        imm_a_mux: IMM_I, imm_b_mux: IMM_I, imm_c_mux: IMM_S, use_rs: 3'b001, writeback: 2'd0};
    localparam offl_instr_t E2 = '{instr_data: 32'h0000007B, instr_mask: 32'h0000007F,
        op_a_mux: OP_IMM, op_b_mux: OP_IMM, op_c_mux: op_sel_e'(2'b11),
        imm_a_mux: IMM_U, imm_b_mux: IMM_S, imm_c_mux: IMM_I, use_rs: 3'b000, writeback: 2'd0};
    localparam offl_instr_t E3 = '{instr_data: 32'h0000002B, instr_mask: 32'h0000007F,
        op_a_mux: OP_RS, op_b_mux: OP_RS, op_c_mux: OP_RS,
        imm_a_mux: IMM_I, imm_b_mux: IMM_I, imm_c_mux: IMM_I, use_rs: 3'b111, writeback: 2'd2};
    localparam offl_instr_t [3:0] Tbl = {E3, E2, E1, E0};

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready, instr_accept, flush;
    logic [31:0] instr_data;
    logic [95:0] rs;
    logic [2:0]  rs_valid;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_instr;
    logic [95:0] req_op;
    logic [1:0]  req_wb;
    logic [1:0]  outstanding;

    int total = 0;
    int fails = 0;

    acc_offload_issue #(
        .NumInstr       (4),
        .NumRs          (3),
        .DataWidth      (32),
        .Depth          (2),
        .MaxOutstanding (2),
        .OfflInstrTable (Tbl)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_valid_i   (instr_valid),
        .instr_ready_o   (instr_ready),
        .instr_data_i    (instr_data),
        .rs_i            (rs),
        .rs_valid_i      (rs_valid),
        .instr_accept_o  (instr_accept),
        .flush_i         (flush),
        .acc_req_valid_o (req_valid),
        .acc_req_ready_i (req_ready),
        .acc_req_instr_o (req_instr),
        .acc_req_op_o    (req_op),
        .acc_req_wb_o    (req_wb),
        .acc_rsp_valid_i (rsp_valid),
        .acc_rsp_ready_o (rsp_ready),
        .outstanding_o   (outstanding)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the rising edge, so registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        instr_valid = 1'b1; instr_data = 32'h00000013; rs = '0; rs_valid = '0;
        #2;
        check("rst_instr_ready", instr_ready, 1'b0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_outstanding", outstanding, 2'd0);
        @(negedge clk);
        rst = 1'b0; instr_valid = 1'b0;
        tick();

        // ADD-like offload, lowest-index entry wins over entry 3
        instr_data = 32'h00C5852B; rs = {32'h99, 32'd7, 32'd5}; rs_valid = 3'b001;
        instr_valid = 1'b1; #1;
        check("add_wait_rs1", instr_ready, 1'b0);
        rs_valid = 3'b011; #1;
        check("add_ready", instr_ready, 1'b1);
        check("add_accept", instr_accept, 1'b1);
        check("add_no_fallthrough", req_valid, 1'b0);
        tick();
        instr_valid = 1'b0;
        check("add_req_valid", req_valid, 1'b1);
        check("add_req_instr", req_instr, 32'h00C5852B);
        check("add_req_op", req_op, {32'h99, 32'd7, 32'd5});
        check("add_req_wb", req_wb, 2'd1);
        check("add_outstanding", outstanding, 2'd1);
        pop_one();
        check("add_popped", req_valid, 1'b0);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check("add_rsp_out", outstanding, 2'd0);

        // I and S immediates
        instr_data = 32'hFFF0005B; rs = {32'h0, 32'h0, 32'h11}; rs_valid = 3'b001;
        instr_valid = 1'b1; #1;
        check("immi_ready", instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0;
        check("immi_ops", req_op, {32'hFFFFFFE0, 32'hFFFFFFFF, 32'h11});
        check("immi_out", outstanding, 2'd0);
        pop_one();

        // U immediate, S immediate, reserved selector
        instr_data = 32'h1234507B; rs_valid = 3'b000; instr_valid = 1'b1; #1;
        check("immu_ready", instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0;
        check("immu_ops", req_op, {32'h0, 32'h00000120, 32'h12345000});
        pop_one();

        // Non-offload instruction
        instr_data = 32'h00000013; instr_valid = 1'b1; #1;
        check("nomatch_ready", instr_ready, 1'b1);
        check("nomatch_accept", instr_accept, 1'b0);
        tick();
        instr_valid = 1'b0;
        check("nomatch_no_push", req_valid, 1'b0);

        // Depth back-pressure and pop-and-push
        rs_valid = 3'b001; instr_data = 32'h0010005B; instr_valid = 1'b1; #1;
        check("fifo_push_a", instr_ready, 1'b1);
        tick();
        instr_data = 32'h0020005B; #1;
        check("fifo_push_b", instr_ready, 1'b1);
        tick();
        instr_data = 32'h0030005B; #1;
        check("fifo_full_stall", instr_ready, 1'b0);
        tick();
        check("fifo_head_stable", req_op[63:32], 32'd1);
        req_ready = 1'b1; #1;
        check("fifo_pop_push", instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0;
        check("fifo_order_b", req_instr, 32'h0020005B);
        tick();
        check("fifo_order_c", req_instr, 32'h0030005B);
        tick();
        check("fifo_drained", req_valid, 1'b0);

        // Credit limit with MaxOutstanding=2 (req_ready still high)
        instr_data = 32'h00C5852B; rs_valid = 3'b011; instr_valid = 1'b1;
        tick();
        check("cred_out1", outstanding, 2'd1);
        tick();
        check("cred_out2", outstanding, 2'd2);
        check("cred_stall", instr_ready, 1'b0);
        rsp_valid = 1'b1; #1;
        check("cred_rsp_ready", instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0;
        check("cred_same_cycle", outstanding, 2'd2);
        tick();
        tick();
        rsp_valid = 1'b0;
        check("cred_drained", outstanding, 2'd0);

        // Flush returns credits of queued writeback entries
        req_ready = 1'b0; instr_valid = 1'b1;
        tick();
        flush = 1'b1; #1;
        check("flush_blocks_push", instr_ready, 1'b0);
        flush = 1'b0; #1;
        tick();
        instr_valid = 1'b0;
        check("flush_pre_out", outstanding, 2'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty", req_valid, 1'b0);
        check("flush_out", outstanding, 2'd0);

        // Asynchronous reset mid-burst
        instr_valid = 1'b1;
        tick();
        tick();
        instr_valid = 1'b0;
        check("burst_valid", req_valid, 1'b1);
        #2;
        rst = 1'b1; #1;
        check("arst_req_valid", req_valid, 1'b0);
        check("arst_out", outstanding, 2'd0);
        check("arst_ready", instr_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_valid", req_valid, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
